// File: rtl/eth_rx_parser.sv
// ---------------------------------------------------------------------------
// eth_rx_parser
// Parses a raw Ethernet byte stream (preamble, SFD, 14-byte header, payload
// with FCS) coming from the read side of a CDC FIFO. Bytes may arrive with
// idle gaps; IDLE_GAP_CYCLES consecutive idle cycles mark the end of a frame.
//
// Ports
//   clkIn, rstIn            : clock, async active-high reset
//   rxDataIn/rxDataValidIn  : input byte stream
//   dstMacOut/srcMacOut     : header MACs, first byte in the MSBs
//   etherTypeOut            : EtherType, first byte in [15:8]
//   headerValidOut          : one-cycle pulse when header fields update
//   payloadDataOut/ValidOut : payload bytes (FCS included)
//   payloadFirstOut/LastOut : first / last payload byte qualifiers
//   payloadLenOut           : payload byte count, valid with payloadLastOut
//   runtErrOut              : frame ended before payload began
//   dropErrOut              : bad preamble or SFD
// ---------------------------------------------------------------------------
module eth_rx_parser #(
  parameter int IDLE_GAP_CYCLES = 4,
  parameter int MIN_PREAMBLE    = 1
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic [7:0]  rxDataIn,
  input  logic        rxDataValidIn,
  output logic [47:0] dstMacOut,
  output logic [47:0] srcMacOut,
  output logic [15:0] etherTypeOut,
  output logic        headerValidOut,
  output logic [7:0]  payloadDataOut,
  output logic        payloadValidOut,
  output logic        payloadFirstOut,
  output logic        payloadLastOut,
  output logic [10:0] payloadLenOut,
  output logic        runtErrOut,
  output logic        dropErrOut
);

  localparam int GW = $clog2(IDLE_GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DROP} state_t;

  state_t         r_state;
  logic [GW-1:0]  r_gap_cnt;
  logic [3:0]     r_pcnt;
  logic [3:0]     r_hcnt;
  logic [103:0]   r_hdr;      // first 13 header bytes; the 14th is merged on the fly
  logic [7:0]     r_held;
  logic           r_held_vld;
  logic           r_first;
  logic [10:0]    r_len;      // payload bytes received so far, including the held one

  logic           w_gap;
  logic [10:0]    w_len_inc;

  // Gap fires on the idle cycle that would bring the count to IDLE_GAP_CYCLES;
  // a valid byte on that cycle wins and no end of frame is declared.
  assign w_gap     = !rxDataValidIn && (r_state != S_IDLE) &&
                     (r_gap_cnt == GW'(IDLE_GAP_CYCLES - 1));
  assign w_len_inc = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_state         <= S_IDLE;
      r_gap_cnt       <= '0;
      r_pcnt          <= '0;
      r_hcnt          <= '0;
      r_hdr           <= '0;
      r_held          <= '0;
      r_held_vld      <= 1'b0;
      r_first         <= 1'b0;
      r_len           <= '0;
      dstMacOut       <= '0;
      srcMacOut       <= '0;
      etherTypeOut    <= '0;
      headerValidOut  <= 1'b0;
      payloadDataOut  <= '0;
      payloadValidOut <= 1'b0;
      payloadFirstOut <= 1'b0;
      payloadLastOut  <= 1'b0;
      payloadLenOut   <= '0;
      runtErrOut      <= 1'b0;
      dropErrOut      <= 1'b0;
    end else begin
      headerValidOut  <= 1'b0;
      payloadDataOut  <= '0;
      payloadValidOut <= 1'b0;
      payloadFirstOut <= 1'b0;
      payloadLastOut  <= 1'b0;
      payloadLenOut   <= '0;
      runtErrOut      <= 1'b0;
      dropErrOut      <= 1'b0;

      if (rxDataValidIn || r_state == S_IDLE || w_gap) r_gap_cnt <= '0;
      else                                             r_gap_cnt <= r_gap_cnt + GW'(1);

      case (r_state)
        S_IDLE: begin
          if (rxDataValidIn) begin
            if (rxDataIn == 8'h55) begin
              r_state <= S_PREAMBLE;
              r_pcnt  <= 4'd1;
            end else begin
              r_state    <= S_DROP;
              dropErrOut <= 1'b1;
            end
          end
        end

        S_PREAMBLE: begin
          if (rxDataValidIn) begin
            if (rxDataIn == 8'h55) begin
              if (r_pcnt != 4'hF) r_pcnt <= r_pcnt + 4'd1;
            end else if (rxDataIn == 8'hD5 && 32'(r_pcnt) >= MIN_PREAMBLE) begin
              r_state <= S_HEADER;
              r_hcnt  <= '0;
            end else begin
              r_state    <= S_DROP;
              dropErrOut <= 1'b1;
            end
          end else if (w_gap) begin
            r_state    <= S_IDLE;
            runtErrOut <= 1'b1;
          end
        end

        S_HEADER: begin
          if (rxDataValidIn) begin
            r_hdr  <= {r_hdr[95:0], rxDataIn};
            r_hcnt <= r_hcnt + 4'd1;
            if (r_hcnt == 4'd13) begin
              dstMacOut      <= r_hdr[103:56];
              srcMacOut      <= r_hdr[55:8];
              etherTypeOut   <= {r_hdr[7:0], rxDataIn};
              headerValidOut <= 1'b1;
              r_state        <= S_PAYLOAD;
              r_held_vld     <= 1'b0;
              r_first        <= 1'b1;
              r_len          <= '0;
            end
          end else if (w_gap) begin
            r_state    <= S_IDLE;
            runtErrOut <= 1'b1;
          end
        end

        S_PAYLOAD: begin
          if (rxDataValidIn) begin
            // A successor arrived, so the held byte is known not to be last.
            if (r_held_vld) begin
              payloadDataOut  <= r_held;
              payloadValidOut <= 1'b1;
              payloadFirstOut <= r_first;
              r_first         <= 1'b0;
            end
            r_held     <= rxDataIn;
            r_held_vld <= 1'b1;
            r_len      <= w_len_inc;
          end else if (w_gap) begin
            if (r_held_vld) begin
              payloadDataOut  <= r_held;
              payloadValidOut <= 1'b1;
              payloadFirstOut <= r_first;
              payloadLastOut  <= 1'b1;
              payloadLenOut   <= r_len;
            end
            r_held_vld <= 1'b0;
            r_first    <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        S_DROP: begin
          if (w_gap) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_parser.sv
module tb_eth_rx_parser;

  localparam int GAP  = 4;
  localparam int MINP = 1;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic [7:0]  rxDataIn;
  logic        rxDataValidIn;
  logic [47:0] dstMacOut, srcMacOut;
  logic [15:0] etherTypeOut;
  logic        headerValidOut;
  logic [7:0]  payloadDataOut;
  logic        payloadValidOut, payloadFirstOut, payloadLastOut;
  logic [10:0] payloadLenOut;
  logic        runtErrOut, dropErrOut;

  eth_rx_parser #(.IDLE_GAP_CYCLES(GAP), .MIN_PREAMBLE(MINP)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .rxDataIn(rxDataIn), .rxDataValidIn(rxDataValidIn),
    .dstMacOut(dstMacOut), .srcMacOut(srcMacOut), .etherTypeOut(etherTypeOut),
    .headerValidOut(headerValidOut), .payloadDataOut(payloadDataOut),
    .payloadValidOut(payloadValidOut), .payloadFirstOut(payloadFirstOut),
    .payloadLastOut(payloadLastOut), .payloadLenOut(payloadLenOut),
    .runtErrOut(runtErrOut), .dropErrOut(dropErrOut)
  );

  always #5 clkIn = ~clkIn;

  typedef struct { logic [47:0] dst; logic [47:0] src; logic [15:0] typ; } hdr_t;
  typedef struct { logic [7:0] d; bit first; bit last; int len; } pay_t;

  hdr_t       hdr_q[$];
  pay_t       pay_q[$];
  bit         err_q[$];   // 0 = runt, 1 = drop
  logic [7:0] frm[$];
  int total = 0;
  int bad   = 0;

  // Reference model: classifies a whole frame from its byte list.
  task automatic model(input bit abort);
    int n, i, np, plen;
    hdr_t h;
    pay_t p;
    n = frm.size();
    i = 0;
    if (n == 0) return;
    if (frm[0] != 8'h55) begin err_q.push_back(1'b1); return; end
    while (i < n && frm[i] == 8'h55) i++;
    np = (i > 15) ? 15 : i;
    if (i == n) begin err_q.push_back(1'b0); return; end
    if (frm[i] != 8'hD5 || np < MINP) begin err_q.push_back(1'b1); return; end
    i++;
    if (n - i < 14) begin err_q.push_back(1'b0); return; end
    for (int k = 0; k < 6; k++) begin
      h.dst[47-8*k -: 8] = frm[i+k];
      h.src[47-8*k -: 8] = frm[i+6+k];
    end
    h.typ = {frm[i+12], frm[i+13]};
    hdr_q.push_back(h);
    i += 14;
    plen = n - i;
    for (int k = 0; k < plen; k++) begin
      if (abort && k == plen - 1) break;
      p.d     = frm[i+k];
      p.first = (k == 0);
      p.last  = !abort && (k == plen - 1);
      p.len   = (plen > 2047) ? 2047 : plen;
      pay_q.push_back(p);
    end
  endtask

  task automatic build(input int npre, input logic [47:0] d, input logic [47:0] s,
                       input logic [15:0] t, input int plen, input bit rnd);
    frm.delete();
    repeat (npre) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int k = 0; k < 6; k++) frm.push_back(d[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) frm.push_back(s[47-8*k -: 8]);
    frm.push_back(t[15:8]);
    frm.push_back(t[7:0]);
    for (int k = 0; k < plen; k++) frm.push_back(rnd ? 8'($urandom) : 8'(k));
  endtask

  task automatic truncate(input int len);
    logic [7:0] dummy;
    while (frm.size() > len) dummy = frm.pop_back();
  endtask

  task automatic send_bytes(input int mingap, input int maxgap);
    for (int k = 0; k < frm.size(); k++) begin
      @(posedge clkIn); #1;
      rxDataValidIn = 1'b1;
      rxDataIn      = frm[k];
      if (k != frm.size() - 1)
        repeat ($urandom_range(maxgap, mingap)) begin
          @(posedge clkIn); #1;
          rxDataValidIn = 1'b0;
        end
    end
  endtask

  task automatic send_frame(input int mingap, input int maxgap, input int extra);
    model(1'b0);
    send_bytes(mingap, maxgap);
    repeat (GAP + extra) begin
      @(posedge clkIn); #1;
      rxDataValidIn = 1'b0;
    end
  endtask

  task automatic chk_reset(input string nm);
    total++;
    if ({dstMacOut, srcMacOut, etherTypeOut, headerValidOut, payloadDataOut, payloadValidOut,
         payloadFirstOut, payloadLastOut, payloadLenOut, runtErrOut, dropErrOut} !== '0) begin
      bad++;
      $display("FAIL %s: outputs not all zero (hv=%b pv=%b last=%b runt=%b drop=%b dst=%h)", nm,
               headerValidOut, payloadValidOut, payloadLastOut, runtErrOut, dropErrOut, dstMacOut);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clkIn) begin
    if (!rstIn) begin
      if (headerValidOut) begin
        hdr_t h;
        total++;
        if (hdr_q.size() == 0) begin
          bad++;
          $display("FAIL hdr_unexpected: got %h/%h/%h, required none", dstMacOut, srcMacOut, etherTypeOut);
        end else begin
          h = hdr_q.pop_front();
          if ({dstMacOut, srcMacOut, etherTypeOut} !== {h.dst, h.src, h.typ}) begin
            bad++;
            $display("FAIL hdr_fields: got %h/%h/%h, required %h/%h/%h",
                     dstMacOut, srcMacOut, etherTypeOut, h.dst, h.src, h.typ);
          end
        end
      end
      if (payloadValidOut) begin
        pay_t p;
        total++;
        if (pay_q.size() == 0) begin
          bad++;
          $display("FAIL pay_unexpected: got byte %h first=%b last=%b, required none",
                   payloadDataOut, payloadFirstOut, payloadLastOut);
        end else begin
          p = pay_q.pop_front();
          if (payloadDataOut !== p.d || payloadFirstOut !== p.first || payloadLastOut !== p.last ||
              (p.last && payloadLenOut !== 11'(p.len))) begin
            bad++;
            $display("FAIL pay_byte: got %h f=%b l=%b len=%0d, required %h f=%b l=%b len=%0d",
                     payloadDataOut, payloadFirstOut, payloadLastOut, payloadLenOut,
                     p.d, p.first, p.last, p.len);
          end
        end
      end else if (payloadFirstOut || payloadLastOut) begin
        total++;
        bad++;
        $display("FAIL pay_qual: first=%b last=%b without valid, required 0/0",
                 payloadFirstOut, payloadLastOut);
      end
      if (runtErrOut || dropErrOut) begin
        bit e;
        total++;
        if (err_q.size() == 0) begin
          bad++;
          $display("FAIL err_unexpected: got runt=%b drop=%b, required none", runtErrOut, dropErrOut);
        end else begin
          e = err_q.pop_front();
          if (runtErrOut !== !e || dropErrOut !== e) begin
            bad++;
            $display("FAIL err_kind: got runt=%b drop=%b, required runt=%b drop=%b",
                     runtErrOut, dropErrOut, !e, e);
          end
        end
      end
    end
  end

  initial begin
    int kind, npre, n;
    logic [7:0] b;
    rstIn = 1'b1;
    rxDataValidIn = 1'b0;
    rxDataIn = 8'h00;
    repeat (3) @(posedge clkIn);
    @(negedge clkIn);
    chk_reset("reset_state");
    @(posedge clkIn); #1;
    rstIn = 1'b0;

    // Reference frame, one byte every other cycle
    build(7, 48'h010203040506, 48'h111213141516, 16'h0800, 46, 1'b0);
    send_frame(1, 1, 0);
    // Same frame, exactly GAP idle cycles, then an IPv6 EtherType
    build(7, 48'h010203040506, 48'h111213141516, 16'h0800, 46, 1'b0);
    send_frame(1, 1, 0);
    build(7, 48'h010203040506, 48'h111213141516, 16'h86DD, 46, 1'b0);
    send_frame(1, 1, 0);
    // Bad SFD position, then a good frame
    frm.delete();
    frm.push_back(8'h55); frm.push_back(8'h55); frm.push_back(8'hAA);
    for (int k = 0; k < 10; k++) frm.push_back(8'($urandom));
    send_frame(0, 3, 0);
    build(3, 48'hA0A1A2A3A4A5, 48'hB0B1B2B3B4B5, 16'h0806, 5, 1'b1);
    send_frame(0, 3, 1);
    // Header runt: preamble, SFD, 8 header bytes
    build(7, 48'h010203040506, 48'h111213141516, 16'h0800, 0, 1'b0);
    truncate(16);
    send_frame(0, 2, 0);
    // Single payload byte
    build(7, 48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h88B5, 0, 1'b0);
    frm.push_back(8'h7E);
    send_frame(0, 3, 0);
    // Zero-length payload
    build(2, 48'h0, 48'hFFFFFFFFFFFF, 16'h1234, 0, 1'b0);
    send_frame(0, 3, 0);
    // Length saturation at 2047
    build(8, 48'h5, 48'h6, 16'h0800, 2060, 1'b1);
    send_frame(0, 0, 0);

    // Reset during payload: 19 bytes emitted, the held 20th is discarded
    build(7, 48'h0A0B0C0D0E0F, 48'h1A1B1C1D1E1F, 16'h0800, 20, 1'b0);
    model(1'b1);
    send_bytes(0, 0);
    @(posedge clkIn); #1;
    rxDataValidIn = 1'b0;
    @(posedge clkIn); #1;
    rstIn = 1'b1;
    @(negedge clkIn);
    chk_reset("reset_midframe");
    @(posedge clkIn); #1;
    rstIn = 1'b0;
    build(7, 48'h010203040506, 48'h111213141516, 16'h0800, 10, 1'b1);
    send_frame(0, 3, 0);

    // Randomized mix
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(5, 0);
      npre = $urandom_range(20, 1);
      build(npre, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
            $urandom_range(70, 0), 1'b1);
      case (kind)
        2: begin
          do b = 8'($urandom); while (b == 8'h55);
          frm[0] = b;
        end
        3: begin
          do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
          frm[npre] = b;
        end
        4: truncate(npre);
        5: begin
          n = npre + 1 + $urandom_range(13, 0);
          truncate(n);
        end
        default: ;
      endcase
      send_frame(0, GAP - 1, $urandom_range(3, 0));
    end

    repeat (10) @(posedge clkIn);
    @(negedge clkIn);
    total++;
    if (hdr_q.size() != 0) begin bad++; $display("FAIL hdr_missing: got %0d pending, required 0", hdr_q.size()); end
    total++;
    if (pay_q.size() != 0) begin bad++; $display("FAIL pay_missing: got %0d pending, required 0", pay_q.size()); end
    total++;
    if (err_q.size() != 0) begin bad++; $display("FAIL err_missing: got %0d pending, required 0", err_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_parser.md
ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 Parameter IDLE_GAP_CYCLES, default 4: consecutive cycles with no valid byte that mark end of frame.
REQ-002 Parameter MIN_PREAMBLE, default 1: minimum 0x55 bytes required before SFD.
REQ-003 clkIn  input  1  250 MHz clock, same domain as the CDC FIFO read side.
REQ-004 rstIn  input  1  reset, asynchronous, active-high.
REQ-005 rxDataIn  input  8  received byte from the CDC FIFO read port.
REQ-006 rxDataValidIn  input  1  rxDataIn valid this cycle; gaps between bytes of one frame are allowed.
REQ-007 dstMacOut  output  48  destination MAC; first received byte in [47:40].
REQ-008 srcMacOut  output  48  source MAC; same byte order.
REQ-009 etherTypeOut  output  16  EtherType; first byte in [15:8].
REQ-010 headerValidOut  output  1  one-cycle pulse; header fields are stable from this pulse until the next frame's header.
REQ-011 payloadDataOut  output  8  payload byte, FCS included.
REQ-012 payloadValidOut  output  1  payloadDataOut valid.
REQ-013 payloadFirstOut  output  1  qualifies the first payload byte.
REQ-014 payloadLastOut  output  1  qualifies the last payload byte.
REQ-015 payloadLenOut  output  11  payload byte count; valid with payloadLastOut.
REQ-016 runtErrOut  output  1  one-cycle pulse; frame ended before payload began.
REQ-017 dropErrOut  output  1  one-cycle pulse; bad preamble or SFD detected.

Function
REQ-018 The FSM SHALL have states IDLE, PREAMBLE, HEADER, PAYLOAD and DROP.
REQ-019 Gap counter: counts cycles with rxDataValidIn=0 while the state is not IDLE; clears on any valid byte; "gap" means the count has reached IDLE_GAP_CYCLES.
REQ-020 IDLE: valid 0x55 -> PREAMBLE with preamble count 1; any other valid byte -> DROP with a dropErrOut pulse.
REQ-021 PREAMBLE on valid 0x55: increment the preamble count, saturating at 15.
REQ-022 PREAMBLE on 0xD5 with count >= MIN_PREAMBLE: go to HEADER.
REQ-023 PREAMBLE on 0xD5 with count < MIN_PREAMBLE, or on any other byte: go to DROP and pulse dropErrOut.
REQ-024 PREAMBLE on gap: go to IDLE and pulse runtErrOut.
REQ-025 HEADER: shift the 14 bytes into dst (0-5), src (6-11) and type (12-13), counted by a 4-bit byte counter.
REQ-026 After the 14th byte, the fields update and headerValidOut pulses on the next clock edge; state goes to PAYLOAD.
REQ-027 HEADER on gap: go to IDLE, pulse runtErrOut, no headerValidOut, header outputs unchanged.
REQ-028 PAYLOAD: a one-byte holding register delays each byte until its successor or a gap is seen, so the last byte can be flagged.
REQ-029 A held byte is emitted with payloadValidOut=1 one cycle after the next valid byte arrives.
REQ-030 On gap, the held byte is emitted with payloadLastOut=1 and payloadLenOut, then the state goes to IDLE.
REQ-031 PAYLOAD on gap with no byte held (zero-length payload): go to IDLE with no payload output and no runtErrOut.
REQ-032 payloadFirstOut is asserted only with the first emitted byte; a single-byte payload asserts first and last together.
REQ-033 payloadLenOut counts all payload bytes, including the 4 FCS bytes, and saturates at 2047.
REQ-034 DROP: ignore bytes until gap, then go to IDLE with no further pulses.
REQ-035 A valid byte arriving on the same cycle the gap count would reach IDLE_GAP_CYCLES clears the counter; no end of frame is declared.
REQ-036 Every pulse output is high for exactly one cycle, and payloadValidOut is never high on two cycles for the same byte.

Reset
REQ-037 While rstIn is high, the state SHALL be IDLE and all counters and the holding register SHALL be clear.
REQ-038 While rstIn is high, every output SHALL be 0.
REQ-039 Reset asserted mid-frame SHALL abort the frame immediately; no last, error or header pulse is emitted for the aborted frame.
REQ-040 The first valid byte after reset release SHALL be parsed from IDLE.

Verification
REQ-041 Frame = 7x55, D5, dst 01..06, src 11..16, type 0800, 46 payload bytes 00..2D, bytes every other cycle -> fields 010203040506/111213141516/0800, headerValidOut once, payload 00..2D, first on 00, last on 2D, payloadLenOut=46.
REQ-042 Same frame, then a 4-cycle idle, then a second frame with type 86DD -> two headerValidOut pulses, second etherTypeOut=86DD, no errors.
REQ-043 55 55 AA ... -> dropErrOut once, no header or payload output until a following valid frame parses correctly.
REQ-044 Preamble, SFD, 8 header bytes, then idle -> runtErrOut once, headerValidOut never asserted.
REQ-045 Full header plus a single payload byte 7E -> one output byte 7E with first=last=1, payloadLenOut=1.
REQ-046 rstIn pulsed after 20 payload bytes -> all outputs 0 with no last pulse; the next frame parses cleanly.
